// File: rtl/cmd_proc_if.sv
// rtl/cmd_proc_if.sv - command processor bus: receiver, motion and transmitter handshakes
interface cmd_proc_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [11:0] speed;
    logic        move_go;
    logic [11:0] move_dist;
    logic        move_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        err;

    modport master (
        input  cmd, cmd_rdy, move_done, tx_done,
        output clr_cmd_rdy, speed, move_go, move_dist, trmt, tx_data, busy, err
    );

    modport slave (
        output cmd, cmd_rdy, move_done, tx_done,
        input  clr_cmd_rdy, speed, move_go, move_dist, trmt, tx_data, busy, err
    );
endinterface

// File: rtl/cmd_proc.sv
// rtl/cmd_proc.sv - executes {opcode,data} commands and returns a one-byte response
module cmd_proc #(
    parameter int          MOVE_TIMEOUT = 1_000_000,
    parameter logic [7:0]  ACK_BYTE     = 8'hA5,
    parameter logic [7:0]  NAK_BYTE     = 8'h5A,
    parameter logic [7:0]  TMO_BYTE     = 8'hEE
) (
    input  logic          clk,
    input  logic          rst,
    cmd_proc_if.master    bus
);

    localparam int TW = (MOVE_TIMEOUT > 1) ? $clog2(MOVE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MOVE_TIMEOUT - 1);

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_SET_SPEED = 4'h1;
    localparam logic [3:0] OP_MOVE      = 4'h2;
    localparam logic [3:0] OP_RD_SPEED  = 4'h3;

    typedef enum logic [2:0] {
        ARM,
        WAIT_CMD,
        DECODE,
        MOVING,
        SEND,
        WAIT_TX
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [11:0]   speed_q, speed_d;
    logic [11:0]   move_dist_q, move_dist_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          err_q, err_d;
    logic          move_go_q, move_go_d;
    logic          trmt_q, trmt_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0]    opcode;
    logic [11:0]   data;

    assign opcode = cmd_q[15:12];
    assign data   = cmd_q[11:0];

    // trmt and move_go are computed one cycle early so they are registered pulses
    // aligned with the first cycle of SEND and MOVING respectively.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        speed_d     = speed_q;
        move_dist_d = move_dist_q;
        tx_data_d   = tx_data_q;
        err_d       = err_q;
        timer_d     = timer_q;
        move_go_d   = 1'b0;
        trmt_d      = 1'b0;

        case (state_q)
            ARM: begin
                state_d = WAIT_CMD;
            end

            WAIT_CMD: begin
                if (bus.cmd_rdy) begin
                    cmd_d   = bus.cmd;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        err_d     = 1'b0;
                        tx_data_d = ACK_BYTE;
                        trmt_d    = 1'b1;
                        state_d   = SEND;
                    end
                    OP_SET_SPEED: begin
                        speed_d   = data;
                        tx_data_d = ACK_BYTE;
                        trmt_d    = 1'b1;
                        state_d   = SEND;
                    end
                    OP_MOVE: begin
                        if (data == 12'd0) begin
                            tx_data_d = NAK_BYTE;
                            trmt_d    = 1'b1;
                            state_d   = SEND;
                        end else begin
                            move_dist_d = data;
                            timer_d     = '0;
                            move_go_d   = 1'b1;
                            state_d     = MOVING;
                        end
                    end
                    OP_RD_SPEED: begin
                        tx_data_d = speed_q[11:4];
                        trmt_d    = 1'b1;
                        state_d   = SEND;
                    end
                    default: begin
                        err_d     = 1'b1;
                        tx_data_d = NAK_BYTE;
                        trmt_d    = 1'b1;
                        state_d   = SEND;
                    end
                endcase
            end

            MOVING: begin
                // completion takes priority over a timeout landing in the same cycle
                if (bus.move_done) begin
                    tx_data_d = ACK_BYTE;
                    trmt_d    = 1'b1;
                    state_d   = SEND;
                end else if (timer_q == TIMER_LAST) begin
                    tx_data_d = TMO_BYTE;
                    err_d     = 1'b1;
                    trmt_d    = 1'b1;
                    state_d   = SEND;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            SEND: begin
                state_d = WAIT_TX;
            end

            WAIT_TX: begin
                if (bus.tx_done) begin
                    state_d = ARM;
                end
            end

            default: begin
                state_d = ARM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARM;
            cmd_q       <= '0;
            speed_q     <= '0;
            move_dist_q <= '0;
            tx_data_q   <= '0;
            err_q       <= 1'b0;
            move_go_q   <= 1'b0;
            trmt_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            speed_q     <= speed_d;
            move_dist_q <= move_dist_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            move_go_q   <= move_go_d;
            trmt_q      <= trmt_d;
            timer_q     <= timer_d;
        end
    end

    // held in ARM during reset, so mask the re-arm pulse until reset is released
    assign bus.clr_cmd_rdy = (state_q == ARM) && !rst;
    assign bus.busy        = (state_q != WAIT_CMD);
    assign bus.speed       = speed_q;
    assign bus.move_go     = move_go_q;
    assign bus.move_dist   = move_dist_q;
    assign bus.trmt        = trmt_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_cmd_proc.sv
// tb/tb_cmd_proc.sv - self-checking bench for cmd_proc with a response scoreboard
module tb_cmd_proc;

    logic clk = 1'b0;
    logic rst;

    cmd_proc_if bus();

    cmd_proc #(.MOVE_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int trmt_cnt    = 0;
    int go_cnt      = 0;
    int clr_cnt     = 0;

    logic [7:0]  exp_q[$];
    logic [11:0] speed_m;

    // scoreboard: every transmitted byte must match the oldest pending expectation
    always @(negedge clk) begin
        if (bus.trmt) begin
            logic [7:0] exp_b;
            trmt_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_trmt: tx_data=%h sent with no response pending", bus.tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.tx_data !== exp_b) begin
                    miscompares++;
                    $display("FAIL response: tx_data=%h expected %h", bus.tx_data, exp_b);
                end
            end
        end
        if (bus.move_go) go_cnt++;
        if (bus.clr_cmd_rdy) clr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        ok = !bus.busy;
    endtask

    task automatic issue(input logic [15:0] c);
        bus.cmd     = c;
        bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b0;
    endtask

    task automatic wait_trmt(input int budget, output int n);
        n = 0;
        while (!bus.trmt && n < budget) begin
            tick();
            n++;
        end
        if (!bus.trmt) n = -1;
    endtask

    task automatic wait_go(input int budget, output int n);
        n = 0;
        while (!bus.move_go && n < budget) begin
            tick();
            n++;
        end
        if (!bus.move_go) n = -1;
    endtask

    // called in the SEND cycle; returns in WAIT_CMD after the re-arm cycle
    task automatic ack_tx();
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
    endtask

    task automatic run_cmd(input logic [15:0] c, input logic [7:0] exp_b, output int lat);
        bit ok;
        int n;
        wait_idle(ok);
        if (!ok) begin
            lat = -1;
            return;
        end
        exp_q.push_back(exp_b);
        issue(c);
        wait_trmt(20, n);
        lat = (n < 0) ? -1 : n + 1;
        if (n >= 0) ack_tx();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd = '0;
        bus.cmd_rdy = 1'b0;
        bus.move_done = 1'b0;
        bus.tx_done = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({bus.speed, bus.move_dist, bus.tx_data, bus.err, bus.move_go, bus.trmt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: speed=%h dist=%h tx=%h err=%b go=%b trmt=%b expected all 0",
                     bus.speed, bus.move_dist, bus.tx_data, bus.err, bus.move_go, bus.trmt);
        end
        vectors++;
        if (bus.clr_cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clr: clr_cmd_rdy=%b expected 0", bus.clr_cmd_rdy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.clr_cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL release_clr: clr_cmd_rdy=%b expected 1", bus.clr_cmd_rdy);
        end
        tick();
        vectors++;
        if (bus.clr_cmd_rdy !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL release_idle: clr_cmd_rdy=%b busy=%b expected 0 0", bus.clr_cmd_rdy, bus.busy);
        end
    endtask

    task automatic test_set_speed();
        int lat;
        int c0 = clr_cnt;
        run_cmd(16'h1ABC, 8'hA5, lat);
        speed_m = 12'hABC;
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL set_speed_latency: trmt after %0d cycles expected 2", lat);
        end
        vectors++;
        if (bus.speed !== 12'hABC) begin
            miscompares++;
            $display("FAIL set_speed_value: speed=%h expected abc", bus.speed);
        end
        vectors++;
        if (clr_cnt - c0 !== 1) begin
            miscompares++;
            $display("FAIL set_speed_clr: clr_cmd_rdy pulses=%0d expected 1", clr_cnt - c0);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL set_speed_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_rd_speed();
        int lat;
        run_cmd(16'h3000, speed_m[11:4], lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL rd_speed_latency: trmt after %0d cycles expected 2", lat);
        end
    endtask

    task automatic test_move();
        bit ok;
        int n;
        int g0 = go_cnt;
        wait_idle(ok);
        exp_q.push_back(8'hA5);
        issue(16'h2010);
        wait_go(5, n);
        vectors++;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL move_go_latency: move_go after %0d cycles expected 1", n);
        end
        vectors++;
        if (bus.move_dist !== 12'h010) begin
            miscompares++;
            $display("FAIL move_dist: move_dist=%h expected 010", bus.move_dist);
        end
        tick();
        vectors++;
        if (bus.move_go !== 1'b0) begin
            miscompares++;
            $display("FAIL move_go_width: move_go=%b expected 0 in second MOVING cycle", bus.move_go);
        end
        repeat (4) tick();
        bus.move_done = 1'b1;
        tick();
        bus.move_done = 1'b0;
        wait_trmt(5, n);
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL move_done_latency: trmt %0d cycles after move_done expected 0", n);
        end
        if (n >= 0) ack_tx();
        vectors++;
        if (go_cnt - g0 !== 1 || bus.move_dist !== 12'h010) begin
            miscompares++;
            $display("FAIL move_go_count: pulses=%0d dist=%h expected 1 010", go_cnt - g0, bus.move_dist);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        int lat;
        wait_idle(ok);
        exp_q.push_back(8'hEE);
        issue(16'h2010);
        wait_go(5, n);
        wait_trmt(40, n);
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL timeout_cycles: trmt %0d cycles after move_go expected 16", n);
        end
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_err: err=%b expected 1", bus.err);
        end
        if (n >= 0) ack_tx();
        run_cmd(16'h0000, 8'hA5, lat);
        vectors++;
        if (bus.err !== 1'b0 || lat !== 2) begin
            miscompares++;
            $display("FAIL nop_clears_err: err=%b latency=%0d expected 0 2", bus.err, lat);
        end
    endtask

    task automatic test_done_at_timeout();
        bit ok;
        int n;
        wait_idle(ok);
        exp_q.push_back(8'hA5);
        issue(16'h2FFF);
        wait_go(5, n);
        repeat (15) tick();
        bus.move_done = 1'b1;
        tick();
        bus.move_done = 1'b0;
        vectors++;
        if (bus.trmt !== 1'b1 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL done_wins: trmt=%b err=%b expected 1 0", bus.trmt, bus.err);
        end
        wait_trmt(20, n);
        if (n >= 0) ack_tx();
    endtask

    task automatic test_illegal();
        int lat;
        int g0;
        int t0;
        run_cmd(16'h7123, 8'h5A, lat);
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_err: err=%b expected 1", bus.err);
        end
        g0 = go_cnt;
        run_cmd(16'h2000, 8'h5A, lat);
        vectors++;
        if (go_cnt !== g0 || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_move: move_go pulses=%0d err=%b expected 0 1", go_cnt - g0, bus.err);
        end
        t0 = trmt_cnt;
        bus.move_done = 1'b1;
        bus.tx_done = 1'b1;
        tick();
        bus.move_done = 1'b0;
        bus.tx_done = 1'b0;
        repeat (3) tick();
        vectors++;
        if (trmt_cnt !== t0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_done: trmt pulses=%0d busy=%b expected 0 0", trmt_cnt - t0, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [11:0] v;
        logic [3:0] op;
        for (int i = 0; i < 6; i++) begin
            v = 12'($urandom);
            run_cmd({4'h1, v}, 8'hA5, lat);
            speed_m = v;
            vectors++;
            if (bus.speed !== v) begin
                miscompares++;
                $display("FAIL b2b_speed: speed=%h expected %h", bus.speed, v);
            end
            run_cmd(16'h3000, v[11:4], lat);
            op = 4'($urandom_range(4, 15));
            run_cmd({op, v}, 8'h5A, lat);
            vectors++;
            if (bus.err !== 1'b1 || lat !== 2) begin
                miscompares++;
                $display("FAIL b2b_illegal: op=%h err=%b latency=%0d expected 1 2", op, bus.err, lat);
            end
        end
    endtask

    task automatic check_aborted(input string tag);
        int t0 = trmt_cnt;
        #1;
        vectors++;
        if (bus.speed !== 12'h000 || bus.trmt !== 1'b0 || bus.move_go !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_abort: speed=%h trmt=%b go=%b busy=%b expected 000 0 0 1",
                     tag, bus.speed, bus.trmt, bus.move_go, bus.busy);
        end
        repeat (2) tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.clr_cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_rearm: clr_cmd_rdy=%b expected 1", tag, bus.clr_cmd_rdy);
        end
        repeat (20) tick();
        vectors++;
        if (trmt_cnt !== t0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_no_resp: trmt pulses=%0d busy=%b expected 0 0", tag, trmt_cnt - t0, bus.busy);
        end
        speed_m = 12'h000;
    endtask

    task automatic test_reset_moving();
        int lat;
        int n;
        run_cmd(16'h1777, 8'hA5, lat);
        issue(16'h2010);
        wait_go(5, n);
        repeat (3) tick();
        rst = 1'b1;
        check_aborted("moving");
    endtask

    task automatic test_reset_wait_tx();
        bit ok;
        int n;
        int lat;
        run_cmd(16'h1321, 8'hA5, lat);
        wait_idle(ok);
        exp_q.push_back(8'h32);
        issue(16'h3000);
        wait_trmt(10, n);
        tick();
        rst = 1'b1;
        check_aborted("wait_tx");
        run_cmd(16'h3000, speed_m[11:4], lat);
        vectors++;
        if (lat !== 2 || bus.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL post_reset_read: latency=%0d tx_data=%h expected 2 00", lat, bus.tx_data);
        end
    endtask

    initial begin
        speed_m = '0;
        test_reset();
        test_set_speed();
        test_rd_speed();
        test_move();
        test_timeout();
        test_done_at_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_moving();
        test_reset_wait_tx();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d responses never sent, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
